// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with x0 hardwired to zero and a sequential clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rnum,
  output logic [NRD*XLEN-1:0] o_rd,
  input  logic                i_wen0,
  input  logic [AW-1:0]       i_wnum0,
  input  logic [XLEN-1:0]     i_wd0,
  input  logic                i_wen1,
  input  logic [AW-1:0]       i_wnum1,
  input  logic [XLEN-1:0]     i_wd1,
  input  logic                i_clr,
  output logic                o_busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            accept;
  logic            we0;
  logic            we1;

  // Writes are only accepted in IDLE and lose to a simultaneous clear request.
  assign accept = (state_q == IDLE) && !i_clr;
  assign we0    = accept && i_wen0 && (i_wnum0 != '0);
  assign we1    = accept && i_wen1 && (i_wnum1 != '0);
  assign o_busy = (state_q == CLEAR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (i_clr) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
          end
        end
        CLEAR: begin
          if (idx_q == AW'(NREGS - 1)) begin
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Port 1 is assigned last so it wins on an address collision.
  always_ff @(posedge i_clk) begin
    if (state_q == CLEAR) begin
      mem_q[idx_q] <= '0;
    end
    if (we0) begin
      mem_q[i_wnum0] <= i_wd0;
    end
    if (we1) begin
      mem_q[i_wnum1] <= i_wd1;
    end
  end

  always_comb begin
    o_rd = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      ra = i_rnum[k*AW +: AW];
      if (ra != '0) begin
        o_rd[k*XLEN +: XLEN] = mem_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
        if (we1 && (i_wnum1 == ra)) begin
          o_rd[k*XLEN +: XLEN] = i_wd1;
        end else if (we0 && (i_wnum0 == ra)) begin
          o_rd[k*XLEN +: XLEN] = i_wd0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected read/busy values, a negedge monitor checks them.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rnum;
  logic [NRD*XLEN-1:0] rd;
  logic                wen0, wen1;
  logic [AW-1:0]       wnum0, wnum1;
  logic [XLEN-1:0]     wd0, wd1;
  logic                clr;
  logic                busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rnum  (rnum),
    .o_rd    (rd),
    .i_wen0  (wen0),
    .i_wnum0 (wnum0),
    .i_wd0   (wd0),
    .i_wen1  (wen1),
    .i_wnum1 (wnum1),
    .i_wd1   (wd1),
    .i_clr   (clr),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = read port, 1 = busy flag
    int          port;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_t         e;
      logic [31:0] act;
      e = sb.pop_front();
      if (e.kind == 0) act = rd[e.port*XLEN +: XLEN];
      else             act = {31'b0, busy};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input logic cond, input string name);
    total++;
    if (cond !== 1'b1) begin
      bad++;
      $display("FAIL %s", name);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input int port, input int addr, input logic [31:0] v, input string name);
    sb_t e;
    rnum[port*AW +: AW] = AW'(addr);
    e.kind = 0; e.port = port; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_busy(input logic v, input string name);
    sb_t e;
    e.kind = 1; e.port = 0; e.exp = {31'b0, v}; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] v);
    if (port == 0) begin wen0 = 1'b1; wnum0 = AW'(addr); wd0 = v; end
    else           begin wen1 = 1'b1; wnum1 = AW'(addr); wd1 = v; end
  endtask

  task automatic idle();
    wen0 = 1'b0;
    wen1 = 1'b0;
  endtask

  // Called right after reset release / clear entry: busy must hold exactly NREGS-1 cycles.
  task automatic sweep_check(input string name);
    for (int i = 0; i < NREGS - 1; i++) begin
      exp_busy(1'b1, name);
      step();
    end
    exp_busy(1'b0, {name, "_end"});
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < NREGS; a += 2) begin
      exp_rd(0, a, 32'h0, name);
      exp_rd(1, a + 1, 32'h0, name);
      step();
    end
  endtask

  initial begin
    int waited;
    rst_n = 1'b1; rnum = '0; clr = 1'b0;
    wen0 = 1'b0; wen1 = 1'b0; wnum0 = '0; wnum1 = '0; wd0 = '0; wd1 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk(busy === 1'b1, "rst_state_busy");
    chk(rd[0 +: XLEN] === 32'h0, "rst_state_x0");
    step();
    exp_busy(1'b1, "rst_busy");
    exp_rd(0, 0, 32'h0, "rst_x0");
    step();
    rst_n = 1'b1;
    sweep_check("post_rst_busy");
    check_all_zero("post_rst_zero");

    wr(0, 5, 32'hDEADBEEF);
    step();
    idle();
    exp_rd(0, 5, 32'hDEADBEEF, "x5_p0");
    exp_rd(1, 5, 32'hDEADBEEF, "x5_p1");
    wr(0, 0, 32'h1);
    step();
    idle();
    exp_rd(0, 0, 32'h0, "x0_wr_ignored");
    step();

    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    step();
    wr(0, 3, 32'hA); wr(1, 4, 32'hB);
    exp_rd(0, 7, 32'h22, "collide_p1_wins");
    step();
    idle();
    exp_rd(0, 3, 32'hA, "dual_x3");
    exp_rd(1, 4, 32'hB, "dual_x4");
    step();

    wr(0, 9, 32'h44);
    step();
    wr(0, 9, 32'h55);
    exp_rd(0, 9, BYP ? 32'h55 : 32'h44, "bypass_x9");
    step();
    idle();
    exp_rd(0, 9, 32'h55, "x9_next");
    step();
    wr(0, 10, 32'h1); wr(1, 10, 32'h2);
    exp_rd(1, 10, BYP ? 32'h2 : 32'h0, "bypass_p1_prio");
    step();
    idle();
    exp_rd(1, 10, 32'h2, "x10_next");
    step();

    for (int a = 1; a < NREGS; a += 2) begin
      wr(0, a, a);
      if (a + 1 < NREGS) wr(1, a + 1, a + 1);
      else               wen1 = 1'b0;
      step();
    end
    idle();
    exp_rd(0, 17, 32'd17, "fill_x17");
    exp_rd(1, 30, 32'd30, "fill_x30");
    step();

    clr = 1'b1;
    wr(0, 2, 32'h99);
    exp_busy(1'b0, "pre_clr_idle");
    step();
    clr = 1'b0;
    idle();
    for (int i = 1; i < NREGS; i++) begin
      exp_busy(1'b1, "clr_busy");
      if (i == 1) begin
        exp_rd(0, 2, 32'd2, "clr_drops_wr");
        exp_rd(1, 1, 32'd1, "sweep_x1_pending");
      end
      if (i == 3) begin
        exp_rd(0, 2, 32'h0, "sweep_x2_cleared");
        exp_rd(1, 3, 32'd3, "sweep_x3_pending");
      end
      if (i == NREGS - 1) begin
        wr(0, 5, 32'h77); wr(1, 6, 32'h66);
        clr = 1'b1;
      end
      step();
    end
    idle();
    clr = 1'b0;
    exp_busy(1'b0, "clr_busy_end");
    check_all_zero("post_clr_zero");

    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 1; i < 10; i++) begin
      exp_busy(1'b1, "mid_busy");
      step();
    end
    rst_n = 1'b0;
    exp_busy(1'b1, "mid_rst_busy");
    step();
    rst_n = 1'b1;
    sweep_check("restart_busy");
    waited = 0;
    while (busy === 1'b1 && waited < NREGS) begin
      step();
      waited++;
    end
    chk(busy === 1'b0, "restart_sweep_wait_expired");
    wr(0, 12, 32'h3C);
    step();
    idle();
    exp_rd(0, 12, 32'h3C, "first_wr_after_sweep");
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL: %0d mismatches", bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, 4..64; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, read port count, 1..4.
REQ-004 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_rnum  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-007 o_rd  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
REQ-008 i_wen0 / i_wnum0 / i_wd0  in  1 / AW / XLEN  write port 0.
REQ-009 i_wen1 / i_wnum1 / i_wd1  in  1 / AW / XLEN  write port 1.
REQ-010 i_clr  in  1  single-cycle request to zero all registers.
REQ-011 o_busy  out  1  high while clear sweep in progress.

Function
REQ-012 Reads combinational; o_rd port k = contents of register i_rnum[k], zero-latency.
REQ-013 Register 0 reads as 0 on every port, always; writes to address 0 have no effect.
REQ-014 Writes take effect at rising edge when wen high, o_busy low, address nonzero.
REQ-015 Both ports writing same nonzero address same cycle: port 1 data stored, port 0 discarded.
REQ-016 Both ports writing different addresses same cycle: both stored.
REQ-017 FSM states IDLE and CLEAR; IDLE -> CLEAR when i_clr high in IDLE; CLEAR -> IDLE after index NREGS-1 cleared.
REQ-018 CLEAR: internal index starts at 1, zeroes one register per cycle, increments by 1; sweep lasts exactly NREGS-1 cycles.
REQ-019 o_busy = 1 exactly while state is CLEAR; first write accepted on cycle after o_busy falls.
REQ-020 While o_busy high: both write ports ignored (dropped, not queued); i_clr ignored.
REQ-021 While o_busy high: reads return current array contents (partially cleared state is visible).
REQ-022 i_clr in IDLE together with a write: clear wins, the write is dropped.
REQ-023 Index counter AW bits wide; no wrap beyond NREGS-1; sweep terminates at last index.

Reset
REQ-024 i_rst_n low asynchronously forces state CLEAR, index 1, o_busy 1.
REQ-025 Storage array has no reset; cleared by the post-reset sweep (NREGS-1 cycles after i_rst_n rises).
REQ-026 Reset asserted mid-sweep or mid-operation restarts the sweep at index 1.
REQ-027 o_rd during reset/sweep undefined for registers not yet cleared, except register 0 = 0.

Configuration
REQ-028 Macro REGFILE_MP_BYPASS_EN defined: read of nonzero address written this cycle (write accepted per REQ-014) returns the write data, port 1 over port 0.
REQ-029 REGFILE_MP_BYPASS_EN undefined: such read returns the previously stored value; new value visible next cycle.

Verification
REQ-030 Release reset -> o_busy high 31 cycles (NREGS=32) then low; all 32 registers read 0.
REQ-031 Write 0xDEADBEEF to x5 on port 0 -> next cycle o_rd port 0 and port 1 with i_rnum=5 both read 0xDEADBEEF; write 0x1 to x0 -> x0 reads 0.
REQ-032 Same cycle port0 writes x7=0x11, port1 writes x7=0x22 -> x7 reads 0x22; port0 x3=0xA, port1 x4=0xB -> both stored.
REQ-033 Read x9 while writing x9=0x55 (old 0x44) -> 0x55 with REGFILE_MP_BYPASS_EN, 0x44 without; 0x55 both builds next cycle.
REQ-034 Fill x1..x31 with index value, pulse i_clr with write x2=0x99 -> write dropped, o_busy 31 cycles, writes during sweep dropped, all registers 0 after.
REQ-035 Assert i_rst_n low at sweep cycle 10, release -> sweep restarts, o_busy high a full 31 cycles.
